seg_display_sched: RTL and testbench

Controller that sequences the shared binary-to-BCD converter and drives the 3-digit multiplexed seven-segment display. On a periodic refresh tick it samples the binary value (encoder count), pulses the converter start, waits for its data-valid, and latches the digits. The latched digits are then scanned onto the common-anode display with over-range indication and a converter timeout guard. It replaces free-running start and edge-clocked latching with a single-clock, handshaked scheduler between the quadrature counter, the converter and the display pins.

---
 rtl/seg_pkg.sv | 29 ++
 rtl/seg_display_sched_if.sv | 14 +
 rtl/seg_glyph_rom.sv | 26 ++
 rtl/seg_display_sched.sv | 172 +++++++++++++++++
 tb/tb_seg_display_sched.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment display scheduler:
// active-low glyphs, the conversion FSM state type and digit-enable levels.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_LATCH = 2'd3
    } sched_state_t;

    // Segment order is [7:1] = a..g, [0] = dp; a zero lights the segment.
    localparam logic [7:0] GLYPH_0   = 8'b0000_0010;
    localparam logic [7:0] GLYPH_1   = 8'b1001_1110;
    localparam logic [7:0] GLYPH_2   = 8'b0010_0100;
    localparam logic [7:0] GLYPH_3   = 8'b0000_1100;
    localparam logic [7:0] GLYPH_4   = 8'b1001_1000;
    localparam logic [7:0] GLYPH_5   = 8'b0100_1000;
    localparam logic [7:0] GLYPH_6   = 8'b0100_0000;
    localparam logic [7:0] GLYPH_7   = 8'b0001_1110;
    localparam logic [7:0] GLYPH_8   = 8'b0000_0000;
    localparam logic [7:0] GLYPH_9   = 8'b0001_1000;
    localparam logic [7:0] SEG_DASH  = 8'b1111_1100;
    localparam logic [7:0] SEG_BLANK = 8'b1111_1111;

    localparam logic EN_ON  = 1'b0;
    localparam logic EN_OFF = 1'b1;

endpackage

// File: rtl/seg_display_sched_if.sv
// Handshake between the display scheduler (master) and the shared
// binary-to-BCD converter (slave).
interface seg_display_sched_if #(
    parameter int INPUT_WIDTH = 13,
    parameter int DIGITS      = 3
);
    logic [INPUT_WIDTH-1:0]  o_Binary;
    logic                    o_Start;
    logic [4*(DIGITS+1)-1:0] i_BCD;
    logic                    i_DV;

    modport master (output o_Binary, output o_Start, input i_BCD, input i_DV);
    modport slave  (input o_Binary, input o_Start, output i_BCD, output i_DV);
endinterface

// File: rtl/seg_glyph_rom.sv
// Combinational BCD nibble to active-low seven-segment glyph lookup;
// codes above 9 render as a blank digit.
import seg_pkg::*;

module seg_glyph_rom (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_glyph
);

    always_comb begin
        case (i_nibble)
            4'd0:    o_glyph = GLYPH_0;
            4'd1:    o_glyph = GLYPH_1;
            4'd2:    o_glyph = GLYPH_2;
            4'd3:    o_glyph = GLYPH_3;
            4'd4:    o_glyph = GLYPH_4;
            4'd5:    o_glyph = GLYPH_5;
            4'd6:    o_glyph = GLYPH_6;
            4'd7:    o_glyph = GLYPH_7;
            4'd8:    o_glyph = GLYPH_8;
            4'd9:    o_glyph = GLYPH_9;
            default: o_glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_sched.sv
// Refresh-driven converter scheduler and multiplexed common-anode display scan.
// Optional LEAD_ZERO_BLANK_EN blanks leading zero digits (rightmost always shown).
import seg_pkg::*;

module seg_display_sched #(
    parameter int INPUT_WIDTH = 13,
    parameter int DIGITS      = 3,
    parameter int SCAN_DIV    = 65536,
    parameter int REFRESH_DIV = 4194304,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   Clk,
    input  logic                   n_reset,
    input  logic [INPUT_WIDTH-1:0] i_Binary,
    seg_display_sched_if.master    conv,
    output logic [7:0]             SevenSegment,
    output logic [DIGITS-1:0]      Enable,
    output logic                   o_Busy,
    output logic                   o_Error
);

    localparam int SLOT_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCAN_W    = $clog2(SCAN_DIV);
    localparam int REFRESH_W = $clog2(REFRESH_DIV);
    localparam int TO_W      = $clog2(TIMEOUT);
    localparam int BCD_W     = 4 * (DIGITS + 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DIGITS - 1);

    logic [REFRESH_W-1:0]   r_refresh_cnt;
    logic [SCAN_W-1:0]      r_scan_cnt;
    sched_state_t           r_state;
    logic [TO_W-1:0]        r_wait_cnt;
    logic [INPUT_WIDTH-1:0] r_binary;
    logic                   r_start;
    logic                   r_busy;
    logic                   r_error;
    logic [BCD_W-1:0]       r_bcd;
    logic [SLOT_W-1:0]      r_slot;
    logic [7:0]             r_seg;
    logic [DIGITS-1:0]      r_enable;

    logic                   w_refresh_tick;
    logic                   w_scan_tick;
    logic [SLOT_W-1:0]      w_digit_idx;
    logic [3:0]             w_nibble;
    logic [7:0]             w_glyph;
    logic                   w_dash;
    logic                   w_blank;
    logic [7:0]             w_seg_next;
    logic [DIGITS-1:0]      w_enable_next;

    assign w_refresh_tick = (r_refresh_cnt == REFRESH_W'(REFRESH_DIV - 1));
    assign w_scan_tick    = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_ff @(posedge Clk or negedge n_reset) begin
        if (!n_reset) begin
            r_refresh_cnt <= '0;
        end else if (w_refresh_tick) begin
            r_refresh_cnt <= '0;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
        end
    end

    // Ticks arriving outside IDLE are simply not looked at, so they are dropped.
    always_ff @(posedge Clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_binary   <= '0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_error    <= 1'b0;
            r_bcd      <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_refresh_tick) begin
                        r_state  <= ST_START;
                        r_binary <= i_Binary;
                        r_start  <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ST_START: begin
                    r_state    <= ST_WAIT;
                    r_wait_cnt <= TO_W'(1);
                end
                ST_WAIT: begin
                    // The wait counter tracks clocks since the start pulse; data-valid wins a tie.
                    if (conv.i_DV) begin
                        r_state <= ST_LATCH;
                        r_bcd   <= conv.i_BCD;
                    end else if (r_wait_cnt == TO_W'(TIMEOUT - 1)) begin
                        r_state <= ST_IDLE;
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_LATCH: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_digit_idx = LAST_SLOT - r_slot;
    assign w_nibble    = r_bcd[{w_digit_idx, 2'b00} +: 4];
    assign w_dash      = (r_bcd[BCD_W-1 -: 4] != 4'd0);

    seg_glyph_rom u_glyph_rom (
        .i_nibble (w_nibble),
        .o_glyph  (w_glyph)
    );

    always_comb begin
`ifdef LEAD_ZERO_BLANK_EN
        // Blank while every digit from the leftmost down to this one is zero.
        w_blank = (w_digit_idx != '0);
        for (int d = 1; d < DIGITS; d++) begin
            if ((SLOT_W'(d) >= w_digit_idx) && (r_bcd[4*d +: 4] != 4'd0)) begin
                w_blank = 1'b0;
            end
        end
`else
        w_blank = 1'b0;
`endif
        if (w_dash) begin
            w_seg_next = SEG_DASH;
        end else if (w_blank) begin
            w_seg_next = SEG_BLANK;
        end else begin
            w_seg_next = w_glyph;
        end
        for (int s = 0; s < DIGITS; s++) begin
            w_enable_next[s] = (SLOT_W'(s) == w_digit_idx) ? EN_ON : EN_OFF;
        end
    end

    // Slot select and glyph load on the same edge, so the pins never mix slots.
    always_ff @(posedge Clk or negedge n_reset) begin
        if (!n_reset) begin
            r_scan_cnt <= '0;
            r_slot     <= '0;
            r_seg      <= SEG_BLANK;
            r_enable   <= {DIGITS{EN_OFF}};
        end else if (w_scan_tick) begin
            r_scan_cnt <= '0;
            r_slot     <= (r_slot == LAST_SLOT) ? '0 : r_slot + 1'b1;
            r_seg      <= w_seg_next;
            r_enable   <= w_enable_next;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign conv.o_Binary = r_binary;
    assign conv.o_Start  = r_start;
    assign SevenSegment  = r_seg;
    assign Enable        = r_enable;
    assign o_Busy        = r_busy;
    assign o_Error       = r_error;

endmodule

// File: tb/tb_seg_display_sched.sv
// Directed bench for seg_display_sched with a behavioural BCD converter
// (data-valid five clocks after start); honours LEAD_ZERO_BLANK_EN.
module tb_seg_display_sched;

    logic        Clk = 1'b0;
    logic        n_reset = 1'b1;
    logic [12:0] i_Binary = '0;
    logic [7:0]  SevenSegment;
    logic [2:0]  Enable;
    logic        o_Busy;
    logic        o_Error;

    int total = 0;
    int bad   = 0;

    logic        m_dv_en = 1'b1;
    logic        f_dv = 1'b0;
    logic        f_bcd_en = 1'b0;
    logic [15:0] f_bcd = '0;
    logic [3:0]  m_cd = '0;
    logic [15:0] m_bcd = '0;

    seg_display_sched_if #(.INPUT_WIDTH(13), .DIGITS(3)) conv_if ();

    seg_display_sched #(
        .INPUT_WIDTH(13), .DIGITS(3), .SCAN_DIV(4), .REFRESH_DIV(64), .TIMEOUT(16)
    ) dut (
        .Clk          (Clk),
        .n_reset      (n_reset),
        .i_Binary     (i_Binary),
        .conv         (conv_if),
        .SevenSegment (SevenSegment),
        .Enable       (Enable),
        .o_Busy       (o_Busy),
        .o_Error      (o_Error)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] to_bcd(input logic [12:0] v);
        int x;
        x = int'(v);
        return {4'((x / 1000) % 10), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    always @(posedge Clk) begin
        if (conv_if.o_Start) begin
            m_cd  <= 4'd5;
            m_bcd <= to_bcd(conv_if.o_Binary);
        end else if (m_cd != 4'd0) begin
            m_cd <= m_cd - 4'd1;
        end
    end

    assign conv_if.i_DV  = (m_dv_en && (m_cd == 4'd1)) || f_dv;
    assign conv_if.i_BCD = f_bcd_en ? f_bcd : m_bcd;

    task automatic wait_start(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (conv_if.o_Start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Let every slot refresh, then record one full scan starting at the leftmost slot.
    task automatic capture_scan(output logic ok, output logic [23:0] segs, output logic [8:0] ens);
        ok = 1'b0;
        segs = '0;
        ens = '0;
        repeat (12) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (Enable === 3'b011) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            segs[23:16] = SevenSegment; ens[8:6] = Enable;
            repeat (4) @(negedge Clk);
            segs[15:8] = SevenSegment; ens[5:3] = Enable;
            repeat (4) @(negedge Clk);
            segs[7:0] = SevenSegment; ens[2:0] = Enable;
        end
    endtask

    task automatic test_reset;
        int k;
        @(negedge Clk);
        total++; if (SevenSegment !== 8'hFF) begin bad++; $display("FAIL rst_seg: got %h want ff", SevenSegment); end
        total++; if (Enable !== 3'b111) begin bad++; $display("FAIL rst_en: got %b want 111", Enable); end
        total++; if ({conv_if.o_Start, o_Busy, o_Error} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {conv_if.o_Start, o_Busy, o_Error}); end
        total++; if (conv_if.o_Binary !== 13'd0) begin bad++; $display("FAIL rst_bin: got %0d want 0", conv_if.o_Binary); end
        i_Binary = 13'd500;
        @(negedge Clk);
        n_reset = 1'b1;
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge Clk);
            if (conv_if.o_Start === 1'b1) begin k = i; break; end
        end
        total++; if (k != 64) begin bad++; $display("FAIL first_start: got cycle %0d want 64", k); end
    endtask

    task automatic test_convert_500;
        logic ok; logic [23:0] segs; logic [8:0] ens;
        i_Binary = 13'd500;
        wait_start(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL s500_start: got %b want 1", ok); end
        total++; if (conv_if.o_Binary !== 13'd500) begin bad++; $display("FAIL s500_bin: got %0d want 500", conv_if.o_Binary); end
        total++; if (o_Busy !== 1'b1) begin bad++; $display("FAIL s500_busy_start: got %b want 1", o_Busy); end
        @(negedge Clk);
        total++; if (conv_if.o_Start !== 1'b0) begin bad++; $display("FAIL s500_pulse_width: got %b want 0", conv_if.o_Start); end
        repeat (5) @(negedge Clk);
        total++; if (o_Busy !== 1'b1) begin bad++; $display("FAIL s500_busy_latch: got %b want 1", o_Busy); end
        @(negedge Clk);
        total++; if (o_Busy !== 1'b0) begin bad++; $display("FAIL s500_busy_done: got %b want 0", o_Busy); end
        capture_scan(ok, segs, ens);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL s500_scan_sync: got %b want 1", ok); end
        total++; if (ens !== 9'b011_101_110) begin bad++; $display("FAIL s500_enables: got %b want 011101110", ens); end
        total++; if (segs !== {8'b0100_1000, 8'b0000_0010, 8'b0000_0010}) begin bad++; $display("FAIL s500_glyphs: got %h want 480202", segs); end
    endtask

    task automatic test_overrange;
        logic ok; logic [23:0] segs; logic [8:0] ens;
        i_Binary = 13'd1234;
        wait_start(ok);
        total++; if (conv_if.o_Binary !== 13'd1234) begin bad++; $display("FAIL ovr_bin: got %0d want 1234", conv_if.o_Binary); end
        capture_scan(ok, segs, ens);
        total++; if (ens !== 9'b011_101_110) begin bad++; $display("FAIL ovr_enables: got %b want 011101110", ens); end
        total++; if (segs !== {3{8'b1111_1100}}) begin bad++; $display("FAIL ovr_dash: got %h want fcfcfc", segs); end
    endtask

    task automatic test_leading_zero;
        logic ok; logic [23:0] segs; logic [8:0] ens; logic [23:0] exp;
`ifdef LEAD_ZERO_BLANK_EN
        exp = {8'hFF, 8'hFF, 8'b0001_1110};
`else
        exp = {8'b0000_0010, 8'b0000_0010, 8'b0001_1110};
`endif
        i_Binary = 13'd7;
        wait_start(ok);
        capture_scan(ok, segs, ens);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL lz_scan_sync: got %b want 1", ok); end
        total++; if (segs !== exp) begin bad++; $display("FAIL lz_glyphs: got %h want %h", segs, exp); end
    endtask

    task automatic test_timeout;
        logic ok; logic [23:0] segs; logic [8:0] ens; logic [23:0] exp7;
`ifdef LEAD_ZERO_BLANK_EN
        exp7 = {8'hFF, 8'hFF, 8'b0001_1110};
`else
        exp7 = {8'b0000_0010, 8'b0000_0010, 8'b0001_1110};
`endif
        m_dv_en = 1'b0;
        i_Binary = 13'd321;
        wait_start(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL to_start: got %b want 1", ok); end
        repeat (15) @(negedge Clk);
        total++; if ({o_Error, o_Busy} !== 2'b01) begin bad++; $display("FAIL to_before: got err/busy %b want 01", {o_Error, o_Busy}); end
        @(negedge Clk);
        total++; if ({o_Error, o_Busy} !== 2'b10) begin bad++; $display("FAIL to_at16: got err/busy %b want 10", {o_Error, o_Busy}); end
        capture_scan(ok, segs, ens);
        total++; if (segs !== exp7) begin bad++; $display("FAIL to_digits_kept: got %h want %h", segs, exp7); end
        wait_start(ok);
        m_dv_en = 1'b1;
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL to_retry: got %b want 1", ok); end
        capture_scan(ok, segs, ens);
        total++; if (segs !== {8'b0000_1100, 8'b0010_0100, 8'b1001_1110}) begin bad++; $display("FAIL to_retry_glyphs: got %h want 0c249e", segs); end
        total++; if (o_Error !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", o_Error); end
    endtask

    task automatic test_dv_idle;
        logic ok; logic [23:0] segs; logic [8:0] ens;
        wait_start(ok);
        repeat (8) @(negedge Clk);
        total++; if (o_Busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", o_Busy); end
        f_bcd = 16'h0999;
        f_bcd_en = 1'b1;
        f_dv = 1'b1;
        repeat (3) @(negedge Clk);
        total++; if (o_Busy !== 1'b0) begin bad++; $display("FAIL idle_dv_busy: got %b want 0", o_Busy); end
        f_dv = 1'b0;
        f_bcd_en = 1'b0;
        capture_scan(ok, segs, ens);
        total++; if (segs !== {8'b0000_1100, 8'b0010_0100, 8'b1001_1110}) begin bad++; $display("FAIL idle_dv_digits: got %h want 0c249e", segs); end
    endtask

    task automatic test_reset_mid;
        logic ok;
        int k;
        wait_start(ok);
        repeat (2) @(negedge Clk);
        total++; if (o_Busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", o_Busy); end
        n_reset = 1'b0;
        #1;
        total++; if (SevenSegment !== 8'hFF) begin bad++; $display("FAIL mid_seg: got %h want ff", SevenSegment); end
        total++; if (Enable !== 3'b111) begin bad++; $display("FAIL mid_en: got %b want 111", Enable); end
        total++; if ({conv_if.o_Start, o_Busy, o_Error} !== 3'b000) begin bad++; $display("FAIL mid_flags: got %b want 000", {conv_if.o_Start, o_Busy, o_Error}); end
        total++; if (conv_if.o_Binary !== 13'd0) begin bad++; $display("FAIL mid_bin: got %0d want 0", conv_if.o_Binary); end
        repeat (3) @(negedge Clk);
        n_reset = 1'b1;
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge Clk);
            if (conv_if.o_Start === 1'b1) begin k = i; break; end
        end
        total++; if (k != 64) begin bad++; $display("FAIL mid_restart: got cycle %0d want 64", k); end
    endtask

    initial begin
        #2 n_reset = 1'b0;
        test_reset();
        test_convert_500();
        test_overrange();
        test_leading_zero();
        test_timeout();
        test_dv_idle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
